// File: rtl/register_file_wb_pkg.sv
// Shared widths, index/word types and scoreboard constants for the WB-stage register file.
package regfile_pkg;

   localparam int DATA_W    = 32;
   localparam int REG_IDX_W = 5;
   localparam int NUM_REGS  = 32;
   localparam int PEND_W    = 2;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0]    word_t;
   typedef logic [PEND_W-1:0]    pend_t;

   localparam reg_idx_t ZERO_REG = 5'd0;
   localparam pend_t    PEND_MAX = '1;

endpackage

// File: rtl/register_file_wb_load_scoreboard.sv
// Per-register in-flight load counters, busy detection, load-use stall and sticky overflow.
// Optional macro REGFILE_BYPASS_EN lets a register being retired this cycle count as not busy.
module load_scoreboard
   import regfile_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_issue_valid,
   input  logic                 i_issue_is_load,
   input  logic [REG_IDX_W-1:0] i_issue_dest,
   input  logic                 i_reg_write,
   input  logic                 i_mem_to_reg,
   input  logic [REG_IDX_W-1:0] i_write_reg,
   input  logic [REG_IDX_W-1:0] i_read_reg1,
   input  logic [REG_IDX_W-1:0] i_read_reg2,
   input  logic                 i_use1,
   input  logic                 i_use2,
   output logic                 o_stall,
   output logic                 o_pend_overflow
);

   pend_t               r_cnt [NUM_REGS];
   logic                r_overflow;
   logic [NUM_REGS-1:0] w_inc;
   logic [NUM_REGS-1:0] w_dec;
   logic [NUM_REGS-1:0] w_busy;
   logic                w_stall;

   // Retire only registers that actually have a load outstanding.
   always_comb begin
      w_dec = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         w_dec[r] = i_reg_write && i_mem_to_reg && (i_write_reg == reg_idx_t'(r)) &&
                    (r_cnt[r] != '0);
      end
   end

   always_comb begin
      w_busy = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
`ifdef REGFILE_BYPASS_EN
         w_busy[r] = (r_cnt[r] != '0) && !((r_cnt[r] == pend_t'(1)) && w_dec[r]);
`else
         w_busy[r] = (r_cnt[r] != '0);
`endif
      end
   end

   assign w_stall = (i_use1 && w_busy[i_read_reg1]) || (i_use2 && w_busy[i_read_reg2]);

   // A stalled instruction never leaves ID, so its issue must not be counted.
   always_comb begin
      w_inc = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         w_inc[r] = i_issue_valid && !w_stall && i_issue_is_load &&
                    (i_issue_dest == reg_idx_t'(r));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_cnt[r] <= '0;
         end
         r_overflow <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (w_inc[r] && !w_dec[r]) begin
               if (r_cnt[r] == PEND_MAX) begin
                  r_overflow <= 1'b1;
               end else begin
                  r_cnt[r] <= r_cnt[r] + 1'b1;
               end
            end else if (w_dec[r] && !w_inc[r]) begin
               r_cnt[r] <= r_cnt[r] - 1'b1;
            end
         end
      end
   end

   assign o_stall         = w_stall;
   assign o_pend_overflow = r_overflow;

endmodule

// File: rtl/register_file_wb.sv
// 32x32 GPR file with one WB write port, two combinational ID read ports and a load scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle WB data to the read ports.
module register_file_wb
   import regfile_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 RegWrite,
   input  logic                 MemtoReg,
   input  logic [REG_IDX_W-1:0] WriteRegister,
   input  logic [DATA_W-1:0]    WriteData,
   input  logic [REG_IDX_W-1:0] ReadRegister1,
   input  logic [REG_IDX_W-1:0] ReadRegister2,
   input  logic                 RegUse1,
   input  logic                 RegUse2,
   input  logic                 IssueValid,
   input  logic                 IssueIsLoad,
   input  logic [REG_IDX_W-1:0] IssueDest,
   output logic [DATA_W-1:0]    ReadData1,
   output logic [DATA_W-1:0]    ReadData2,
   output logic                 LoadUseStall,
   output logic                 PendOverflow
);

   word_t r_regs [NUM_REGS];
   logic  w_hit1;
   logic  w_hit2;

   // Entry 0 is cleared by reset and never written, so it always reads as zero.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (RegWrite && (WriteRegister != ZERO_REG)) begin
         r_regs[WriteRegister] <= WriteData;
      end
   end

   always_comb begin
      w_hit1 = 1'b0;
      w_hit2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
      w_hit1 = Rst_n && RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_REG);
      w_hit2 = Rst_n && RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_REG);
`endif
      ReadData1 = w_hit1 ? WriteData : r_regs[ReadRegister1];
      ReadData2 = w_hit2 ? WriteData : r_regs[ReadRegister2];
   end

   load_scoreboard u_scoreboard (
      .i_clk           (Clk),
      .i_rst_n         (Rst_n),
      .i_issue_valid   (IssueValid),
      .i_issue_is_load (IssueIsLoad),
      .i_issue_dest    (IssueDest),
      .i_reg_write     (RegWrite),
      .i_mem_to_reg    (MemtoReg),
      .i_write_reg     (WriteRegister),
      .i_read_reg1     (ReadRegister1),
      .i_read_reg2     (ReadRegister2),
      .i_use1          (RegUse1),
      .i_use2          (RegUse2),
      .o_stall         (LoadUseStall),
      .o_pend_overflow (PendOverflow)
   );

endmodule
